alu_ctrl: RTL

ALU_CTRL -- requirements
Module: alu_ctrl

---
 rtl/alu_ctrl.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/alu_ctrl.sv
// -----------------------------------------------------------------------------
// alu_ctrl
//
// Purpose:
//   Sequencer that sits in front of an external registered ALU. It owns a
//   4 x 8-bit register file, accepts one instruction at a time, drives the ALU
//   operands for one cycle, then writes the ALU result back into the register
//   file. Each instruction takes three cycles: IDLE (accept), ISSUE (drive
//   operands) and WB (write back).
//
// Ports:
//   clk, rst            clock and synchronous active-high reset
//   instr_valid_in      instruction offered
//   instr_in[7:0]       [7:6] op, [5:4] dst, [3:2] srcx, [1:0] srcy
//   instr_ready_out     high only in IDLE
//   wr_en_in/wr_sel_in/wr_data_in   external register write port
//   rd_sel_in/rd_data_out           combinational debug read port
//   alu_x_out/alu_y_out/alu_op_out  ALU operands and opcode
//   alu_z_in            ALU result, valid one cycle after the operands
//   done_out            one-cycle pulse after each write-back
//   result_out          value written by the most recent retired instruction
//   instr_cnt_out       retired-instruction counter, wraps at 256
// -----------------------------------------------------------------------------
module alu_ctrl (
  input  logic       clk,
  input  logic       rst,
  input  logic       instr_valid_in,
  input  logic [7:0] instr_in,
  output logic       instr_ready_out,
  input  logic       wr_en_in,
  input  logic [1:0] wr_sel_in,
  input  logic [7:0] wr_data_in,
  input  logic [1:0] rd_sel_in,
  output logic [7:0] rd_data_out,
  output logic [7:0] alu_x_out,
  output logic [7:0] alu_y_out,
  output logic [1:0] alu_op_out,
  input  logic [7:0] alu_z_in,
  output logic       done_out,
  output logic [7:0] result_out,
  output logic [7:0] instr_cnt_out
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WB    = 2'd2
  } state_t;

  state_t     state_reg, state_next;
  logic [7:0] instr_reg;
  logic [7:0] regs_reg [4];
  logic       done_reg;
  logic [7:0] result_reg;
  logic [7:0] cnt_reg;

  // Fields of the latched instruction.
  logic [1:0] op_f, dst_f, srcx_f, srcy_f;
  assign op_f   = instr_reg[7:6];
  assign dst_f  = instr_reg[5:4];
  assign srcx_f = instr_reg[3:2];
  assign srcy_f = instr_reg[1:0];

  logic accept, wb_fire;
  assign accept  = (state_reg == IDLE) && instr_valid_in;
  assign wb_fire = (state_reg == WB);

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (instr_valid_in) state_next = ISSUE;
      ISSUE:   state_next = WB;
      WB:      state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      instr_reg <= 8'h00;
    end else if (accept) begin
      instr_reg <= instr_in;
    end
  end

  // ---------------------------------------------------------------------------
  // Register file. The write-back is checked first so that it overrides an
  // external write to the same register on the same edge; writes to other
  // registers still land.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (rst) begin
        regs_reg[i] <= 8'h00;
      end else if (wb_fire && (dst_f == i[1:0])) begin
        regs_reg[i] <= alu_z_in;
      end else if (wr_en_in && (wr_sel_in == i[1:0])) begin
        regs_reg[i] <= wr_data_in;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Retirement bookkeeping
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      done_reg   <= 1'b0;
      result_reg <= 8'h00;
      cnt_reg    <= 8'h00;
    end else begin
      done_reg <= wb_fire;
      if (wb_fire) begin
        result_reg <= alu_z_in;
        cnt_reg    <= cnt_reg + 8'd1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs. Operands are read combinationally from the register file in
  // ISSUE; the ALU registers them at the end of that cycle, so a write landing
  // on that same edge cannot disturb them.
  // ---------------------------------------------------------------------------
  assign instr_ready_out = (state_reg == IDLE);
  assign rd_data_out     = regs_reg[rd_sel_in];
  assign alu_x_out       = (state_reg == ISSUE) ? regs_reg[srcx_f] : 8'h00;
  assign alu_y_out       = (state_reg == ISSUE) ? regs_reg[srcy_f] : 8'h00;
  assign alu_op_out      = (state_reg == ISSUE) ? op_f : 2'b11;
  assign done_out        = done_reg;
  assign result_out      = result_reg;
  assign instr_cnt_out   = cnt_reg;

endmodule
